// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM input in sys_clk cycles
module pwm_capture #(
    parameter int CNT_LENGTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  sys_en,
    input  logic                  pwm_in,
    input  logic                  ovf_clr,
    output logic [CNT_LENGTH-1:0] period,
    output logic [CNT_LENGTH-1:0] high_time,
    output logic                  cap_valid,
    output logic                  cap_ready,
    output logic                  ovf_pulse,
    output logic                  ovf_flag,
    output logic                  pwm_level
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2} state_t;

    localparam logic [CNT_LENGTH-1:0] CNT_ONE = CNT_LENGTH'(1);
    localparam logic [CNT_LENGTH-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
    logic                   prev_q, prev_d;
    logic [CNT_LENGTH-1:0]  cnt_q, cnt_d;
    logic [CNT_LENGTH-1:0]  hi_shadow_q, hi_shadow_d;
    logic [CNT_LENGTH-1:0]  period_q, period_d;
    logic [CNT_LENGTH-1:0]  high_time_q, high_time_d;
    logic                   cap_valid_q, cap_valid_d;
    logic                   cap_ready_q, cap_ready_d;
    logic                   ovf_pulse_q, ovf_pulse_d;
    logic                   ovf_flag_q, ovf_flag_d;
    logic                   sync_q, rise, fall;

    assign sync_q       = sync_chain_q[SYNC_STAGES-1];
    assign rise         = sync_q & ~prev_q;
    assign fall         = ~sync_q & prev_q;
    assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], pwm_in};
    assign prev_d       = sync_q;

    // Next-state logic: disable forces IDLE; a timeout drops back to ARM so partial periods are never reported
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_shadow_d = hi_shadow_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        cap_valid_d = 1'b0;
        cap_ready_d = cap_ready_q;
        ovf_pulse_d = 1'b0;
        ovf_flag_d  = ovf_flag_q & ~ovf_clr;
        if (!sys_en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            cap_ready_d = 1'b0;
            ovf_flag_d  = ovf_flag_q;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (fall) hi_shadow_d = cnt_q;
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hi_shadow_q;
                        cap_valid_d = 1'b1;
                        cap_ready_d = 1'b1;
                        cnt_d       = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_pulse_d = 1'b1;
                        ovf_flag_d  = 1'b1;
                        cap_ready_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = ARM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // All state, synchroniser and registered outputs, cleared asynchronously
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            sync_chain_q <= '0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            hi_shadow_q  <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            cap_valid_q  <= 1'b0;
            cap_ready_q  <= 1'b0;
            ovf_pulse_q  <= 1'b0;
            ovf_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_chain_q <= sync_chain_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            hi_shadow_q  <= hi_shadow_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            cap_valid_q  <= cap_valid_d;
            cap_ready_q  <= cap_ready_d;
            ovf_pulse_q  <= ovf_pulse_d;
            ovf_flag_q   <= ovf_flag_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign cap_valid = cap_valid_q;
    assign cap_ready = cap_ready_q;
    assign ovf_pulse = ovf_pulse_q;
    assign ovf_flag  = ovf_flag_q;
    assign pwm_level = sync_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table, directed and random checks of pwm_capture against a timestamp model
module tb_pwm_capture;
    localparam int W = 8;
    localparam int MAXC = (1 << W) - 1;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         sys_en = 1'b0;
    logic         pwm_in = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] period, high_time;
    logic         cap_valid, cap_ready, ovf_pulse, ovf_flag, pwm_level;

    pwm_capture #(.CNT_LENGTH(W), .SYNC_STAGES(2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_en(sys_en), .pwm_in(pwm_in),
        .ovf_clr(ovf_clr), .period(period), .high_time(high_time), .cap_valid(cap_valid),
        .cap_ready(cap_ready), .ovf_pulse(ovf_pulse), .ovf_flag(ovf_flag), .pwm_level(pwm_level)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: timestamps of the last rise/fall seen by the capture logic
    typedef enum {M_IDLE, M_WAIT, M_MEAS} mmode_t;
    mmode_t       m_mode;
    int           m_t, t_rise, t_fall;
    logic         h1, h2, h3;
    logic [W-1:0] m_period, m_high;
    logic         m_valid, m_ready, m_ovfp, m_flag;

    typedef struct {
        int           hi;
        int           lo;
        logic [W-1:0] exp_period;
        logic [W-1:0] exp_high;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_t = 0; t_rise = 0; t_fall = 0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        m_period = '0; m_high = '0;
        m_valid = 1'b0; m_ready = 1'b0; m_ovfp = 1'b0; m_flag = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, compare every output
    task automatic step(input logic en, input logic in, input logic clr);
        logic rise, fall;
        sys_en = en; pwm_in = in; ovf_clr = clr;
        @(posedge sys_clk);
        #1;
        rise = h2 & ~h3;
        fall = ~h2 & h3;
        m_valid = 1'b0;
        m_ovfp = 1'b0;
        if (!en) begin
            m_mode = M_IDLE;
            m_ready = 1'b0;
        end else begin
            if (clr) m_flag = 1'b0;
            case (m_mode)
                M_IDLE: m_mode = M_WAIT;
                M_WAIT: if (rise) begin m_mode = M_MEAS; t_rise = m_t; end
                M_MEAS: begin
                    if (fall) t_fall = m_t;
                    if (rise) begin
                        m_period = W'(m_t - t_rise);
                        m_high = W'(t_fall - t_rise);
                        m_valid = 1'b1;
                        m_ready = 1'b1;
                        t_rise = m_t;
                    end else if (m_t - t_rise == MAXC) begin
                        m_ovfp = 1'b1;
                        m_flag = 1'b1;
                        m_ready = 1'b0;
                        m_mode = M_WAIT;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        n_total++;
        if (period === m_period && high_time === m_high && cap_valid === m_valid &&
            cap_ready === m_ready && ovf_pulse === m_ovfp && ovf_flag === m_flag && pwm_level === h1)
            n_pass++;
        else
            $display("FAIL cycle %0d: got p=%0d h=%0d v=%b r=%b op=%b of=%b lvl=%b expected p=%0d h=%0d v=%b r=%b op=%b of=%b lvl=%b",
                     m_t, period, high_time, cap_valid, cap_ready, ovf_pulse, ovf_flag, pwm_level,
                     m_period, m_high, m_valid, m_ready, m_ovfp, m_flag, h1);
        h3 = h2; h2 = h1; h1 = in;
        m_t++;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (hi) step(1'b1, 1'b1, 1'b0);
            repeat (lo) step(1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic seen;
        tbl[0] = '{30, 70, 8'd100, 8'd30};
        tbl[1] = '{3, 7, 8'd10, 8'd3};
        tbl[2] = '{1, 1, 8'd2, 8'd1};
        tbl[3] = '{100, 155, 8'd255, 8'd100};
        tbl[4] = '{1, 254, 8'd255, 8'd1};
        tbl[5] = '{5, 3, 8'd8, 8'd5};
        model_reset();
        #1;
        check("reset_period", period, 0);
        check("reset_high_time", high_time, 0);
        check("reset_flags", {cap_valid, cap_ready, ovf_pulse, ovf_flag, pwm_level}, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            wave(tbl[i].hi, tbl[i].lo, 3);
            check($sformatf("tbl%0d_period", i), period, tbl[i].exp_period);
            check($sformatf("tbl%0d_high", i), high_time, tbl[i].exp_high);
            check($sformatf("tbl%0d_ready", i), cap_ready, 1);
            check($sformatf("tbl%0d_no_ovf", i), ovf_flag, 0);
        end

        // Stuck low after a rise: timeout, sticky flag, period holds
        repeat (4) step(1'b1, 1'b1, 1'b0);
        repeat (300) step(1'b1, 1'b0, 1'b0);
        check("timeout_flag", ovf_flag, 1);
        check("timeout_ready", cap_ready, 0);
        check("timeout_period_holds", period, 8);
        step(1'b1, 1'b0, 1'b1);
        check("ovf_clr", ovf_flag, 0);

        // Clear held through a second timeout: set wins on the pulse cycle
        seen = 1'b0;
        repeat (4) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (ovf_pulse) begin
                seen = 1'b1;
                check("set_wins", ovf_flag, 1);
            end
        end
        check("second_timeout_seen", seen, 1);
        check("flag_cleared_after", ovf_flag, 0);

        // Disable mid-period, then re-enable
        wave(10, 10, 3);
        repeat (4) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        check("en_drop_period_holds", period, 20);
        check("en_drop_ready", cap_ready, 0);
        wave(6, 4, 3);

        // Disable on the very cycle a capture would be taken
        wave(5, 5, 3);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("en_drop_no_capture", cap_valid, 0);
        check("en_drop_capture_period", period, 10);
        wave(5, 5, 3);

        // Asynchronous reset mid-measurement
        repeat (4) step(1'b1, 1'b0, 1'b0);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("async_reset_period", period, 0);
        check("async_reset_flags", {cap_valid, cap_ready, ovf_pulse, ovf_flag, pwm_level, high_time}, 0);
        model_reset();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        wave(9, 11, 4);
        check("post_reset_period", period, 20);

        // Random waveforms with occasional disables and clears
        for (int i = 0; i < 40; i++) begin
            int hi, lo;
            hi = $urandom_range(1, 140);
            lo = $urandom_range(1, 140);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 5)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            repeat (hi) step(1'b1, 1'b1, 1'($urandom_range(0, 19) == 0));
            repeat (lo) step(1'b1, 1'b0, 1'($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
